fir4_chan_sched: RTL
====================

Name: fir4_chan_sched

Overview:
Time-multiplexed channel scheduler that shares one 4-tap unsigned averaging FIR datapath among NCH independent sample streams. It round-robin arbitrates between per-channel valid/ready inputs and keeps a private 3-sample tap history per channel. It issues one 4-tap sum per granted sample, tagged with its channel index, over a valid/ready output. It sits between the multi-channel ADC front end and the per-channel averaging consumers.

Parameters:
W, 16, sample width in bits (unsigned)
NCH, 4, number of channels (2..16)
CW, $clog2(NCH), channel index width (derived, not overridden)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
in_valid  in  NCH  per-channel sample valid
in_data  in  NCH*W  per-channel samples, channel c at bits [c*W +: W]
in_ready  out  NCH  per-channel accept; one-hot or zero
out_valid  out  1  result valid
out_ready  in  1  downstream accept
out_data  out  W+2  4-tap sum x[n]+x[n-1]+x[n-2]+x[n-3] of out_chan
out_chan  out  CW  channel index of out_data

Behaviour:
- Reset: clk and reset as above; reset is asynchronous and active-high. On assertion: FSM=IDLE, out_valid=0, out_data=0, out_chan=0, in_ready=0, all histories=0, rr pointer=NCH-1, so channel 0 wins first. This applies mid-operation too; a held result is discarded.
- FSM states: IDLE, ADD, HOLD.
- IDLE: if any in_valid, winner g = first asserted channel searching from rr+1 upward with wrap. in_ready[g]=1 combinationally in this cycle only. On the clock edge: capture in_data[g] and g, set rr<=g, go to ADD. If no in_valid, stay in IDLE. in_ready is 0 in every other state.
- ADD: sum = x + h0[g] + h1[g] + h2[g], zero-extended to W+2 bits; no overflow is possible (max 4*(2^W-1)). Register out_data<=sum, out_chan<=g, out_valid<=1. Shift history: h2<=h1, h1<=h0, h0<=x. Go to HOLD.
- HOLD: out_valid=1. out_data and out_chan are stable until handshake. On out_valid&out_ready, go to IDLE and out_valid<=0. Otherwise stay.
- Throughput: a minimum of 3 cycles per sample (grant, add, handshake). Grant-to-out_valid latency is 2 edges.
- Sources must hold in_valid and in_data until in_ready. A channel that drops in_valid before its grant is skipped without effect.
- Only the granted channel's history changes. Other channels' histories are bit-exact preserved across any interleaving.
- The rr pointer advances only on grant. A lone requesting channel is granted repeatedly.

Optional Feature:
Macro FIR_SCHED_FLUSH_EN.
- Defined: adds ports flush (in, 1) and flush_chan (in, CW). When flush is high on an edge, h0/h1/h2 of flush_chan are cleared to 0.
- If that channel is in ADD on the same edge, the flush wins for the history, but out_data still carries the pre-flush sum.
- Not defined: no extra ports. Histories clear only on reset.

Test Plan:
- After reset, with out_ready=1, ch0 sends 100, 200, 300, 400 -> out_data 100, 300, 600, 1000, out_chan=0 each time, in_ready[0] pulses once per sample.
- ch0 sends 0xFFFF four times, interleaved with ch1 sending 1 -> ch0's fourth out_data=0x3FFFC, every ch1 output = 1, 2, 3, ... (history isolation).
- All four in_valid held high from reset, out_ready=1 -> grant/out_chan order 0,1,2,3,0,1; in_ready never has more than one bit set.
- Result in HOLD with out_ready low for 5 cycles -> out_valid stays 1, out_data/out_chan unchanged, in_ready=0 throughout; the handshake then occurs and the FSM returns to IDLE.
- Assert reset asynchronously mid-HOLD (between edges) -> out_valid falls immediately. Then ch0 sends 7 -> out_data=7.
- With FIR_SCHED_FLUSH_EN: ch2 sends 10, 20, then flush ch2, then sends 5 -> out_data 10, 30, 5.

Source files
------------

// File: rtl/fir4_chan_sched.sv
// Round-robin scheduler sharing one 4-tap unsigned summing FIR among NCH sample streams.
// Optional macro FIR_SCHED_FLUSH_EN adds flush/flush_chan ports to clear one channel's history.
module fir4_chan_sched #(
    parameter int W = 16,
    parameter int NCH = 4,
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NCH-1:0]    in_valid,
    input  logic [NCH*W-1:0]  in_data,
    output logic [NCH-1:0]    in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [W+1:0]      out_data,
    output logic [CW-1:0]     out_chan
`ifdef FIR_SCHED_FLUSH_EN
    ,
    input  logic              flush,
    input  logic [CW-1:0]     flush_chan
`endif
);

    typedef enum logic [1:0] {IDLE, ADD, HOLD} state_t;

    state_t          state_reg, state_next;
    logic [CW-1:0]   rr_reg;
    logic [CW-1:0]   chan_reg;
    logic [W-1:0]    sample_reg;
    logic [W+1:0]    out_data_reg;
    logic [CW-1:0]   out_chan_reg;
    logic            out_valid_reg;

    logic [W-1:0]    in_words [NCH];
    logic [W-1:0]    h0_all [NCH];
    logic [W-1:0]    h1_all [NCH];
    logic [W-1:0]    h2_all [NCH];

    logic            grant_found;
    logic [CW-1:0]   grant_idx;
    logic [W+1:0]    sum;

    // Per-channel history; only the channel in ADD shifts, a flush overrides the shift.
    for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
        logic [W-1:0] h0_reg, h1_reg, h2_reg;
        logic         flush_hit;
        logic         shift_en;

`ifdef FIR_SCHED_FLUSH_EN
        assign flush_hit = flush && (flush_chan == CW'(gi));
`else
        assign flush_hit = 1'b0;
`endif
        assign shift_en = (state_reg == ADD) && (chan_reg == CW'(gi));

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                h0_reg <= '0;
                h1_reg <= '0;
                h2_reg <= '0;
            end else if (flush_hit) begin
                h0_reg <= '0;
                h1_reg <= '0;
                h2_reg <= '0;
            end else if (shift_en) begin
                h2_reg <= h1_reg;
                h1_reg <= h0_reg;
                h0_reg <= sample_reg;
            end
        end

        assign in_words[gi] = in_data[gi*W +: W];
        assign h0_all[gi]   = h0_reg;
        assign h1_all[gi]   = h1_reg;
        assign h2_all[gi]   = h2_reg;
    end

    // Search starts just after the last winner and wraps.
    always_comb begin
        logic [CW-1:0] cand;
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int i = 1; i <= NCH; i++) begin
            cand = CW'((int'(rr_reg) + i) % NCH);
            if (!grant_found && in_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_comb begin
        in_ready = '0;
        if (state_reg == IDLE && grant_found) begin
            in_ready[grant_idx] = 1'b1;
        end
    end

    assign sum = {2'b00, sample_reg} + {2'b00, h0_all[chan_reg]}
               + {2'b00, h1_all[chan_reg]} + {2'b00, h2_all[chan_reg]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (grant_found) state_next = ADD;
            ADD:     state_next = HOLD;
            HOLD:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_reg        <= CW'(NCH - 1);
            chan_reg      <= '0;
            sample_reg    <= '0;
            out_data_reg  <= '0;
            out_chan_reg  <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (grant_found) begin
                        sample_reg <= in_words[grant_idx];
                        chan_reg   <= grant_idx;
                        rr_reg     <= grant_idx;
                    end
                end
                ADD: begin
                    out_data_reg  <= sum;
                    out_chan_reg  <= chan_reg;
                    out_valid_reg <= 1'b1;
                end
                HOLD: begin
                    if (out_ready) out_valid_reg <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_chan  = out_chan_reg;

endmodule
